par_int_ctrl: RTL and testbench

//  Transaction sequencer for the 8-bit parallel interface datapath (din/dout/dir registers + tristates).

---
 rtl/par_int_ctrl.sv | 150 +++++++++++++++
 tb/tb_par_int_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/par_int_ctrl.sv
// Host-side sequencer for the 8-bit parallel interface: one request at a time,
// setup/strobe/release ordering on the interface lines, 4-phase stb/ack with timeouts.
module par_int_ctrl #(
    parameter int SETUP_CYC = 2,
    parameter int TO_CYC    = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic [1:0] op_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] rdata_o,
    output logic       w_r_o,
    output logic [1:0] sel_o,
    output logic [7:0] pdata_out_o,
    input  logic [7:0] pdata_in_i,
    output logic       stb_o,
    input  logic       ack_i
);

    localparam int CNT_MAX = (SETUP_CYC > TO_CYC) ? SETUP_CYC : TO_CYC;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] TO_LOAD    = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

    localparam logic [1:0] OP_RD_DIN = 2'b10;
    localparam logic [1:0] OP_INV    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          stb_q;
    logic          w_r_q;
    logic [1:0]    sel_q;
    logic [7:0]    pdata_out_q;
    logic [7:0]    rdata_q;

    // Transaction FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            stb_q       <= 1'b0;
            w_r_q       <= 1'b1;
            sel_q       <= 2'b00;
            pdata_out_q <= 8'h00;
            rdata_q     <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        sel_q       <= op_i;
                        pdata_out_q <= wdata_i;
                        busy_q      <= 1'b1;
                        if (op_i == OP_INV) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            w_r_q   <= (op_i == OP_RD_DIN);
                            cnt_q   <= SETUP_LOAD;
                            state_q <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == CNT_ZERO) begin
                        stb_q   <= 1'b1;
                        cnt_q   <= TO_LOAD;
                        state_q <= ST_WAIT_ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_i) begin
                        stb_q <= 1'b0;
                        if (sel_q == OP_RD_DIN) begin
                            rdata_q <= pdata_in_i;
                        end
                        cnt_q   <= TO_LOAD;
                        state_q <= ST_WAIT_REL;
                    end else if (cnt_q == CNT_ZERO) begin
                        stb_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_WAIT_REL: begin
                    // Interface lines stay untouched until the peripheral drops ack.
                    if (!ack_i) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_ZERO) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    w_r_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    stb_q   <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    w_r_q   <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign stb_o       = stb_q;
    assign w_r_o       = w_r_q;
    assign sel_o       = sel_q;
    assign pdata_out_o = pdata_out_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_par_int_ctrl.sv
// Directed bench for par_int_ctrl: a transaction-level timeline model checked every cycle,
// plus literal pins on stb width, done count and rdata.
module tb_par_int_ctrl;

    localparam int SETUP_CYC = 2;
    localparam int TO_CYC    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] op;
    logic [7:0] wdata;
    logic [7:0] pdata_in;
    logic       ack;
    logic       busy_o, done_o, err_o, w_r_o, stb_o;
    logic [7:0] rdata_o, pdata_out_o;
    logic [1:0] sel_o;

    par_int_ctrl #(.SETUP_CYC(SETUP_CYC), .TO_CYC(TO_CYC)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .wdata_i(wdata),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .w_r_o(w_r_o), .sel_o(sel_o), .pdata_out_o(pdata_out_o),
        .pdata_in_i(pdata_in), .stb_o(stb_o), .ack_i(ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit chk_en = 1'b0;
    int done_seen, stb_seen, busy_seen;

    // Expected outputs after the most recent clock edge.
    logic       m_busy, m_done, m_err, m_stb, m_wr;
    logic [1:0] m_sel;
    logic [7:0] m_pout, m_rdata;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy_o), int'(m_busy));
            chk("done", int'(done_o), int'(m_done));
            chk("err", int'(err_o), int'(m_err));
            chk("stb", int'(stb_o), int'(m_stb));
            chk("w_r", int'(w_r_o), int'(m_wr));
            chk("sel", int'(sel_o), int'(m_sel));
            chk("pdata_out", int'(pdata_out_o), int'(m_pout));
            chk("rdata", int'(rdata_o), int'(m_rdata));
            if (done_o) done_seen++;
            if (stb_o) stb_seen++;
            if (busy_o) busy_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_stb = 1'b0; m_wr = 1'b1;
        m_sel = 2'b00; m_pout = 8'h00; m_rdata = 8'h00;
    endtask

    // ack_from/ack_len: ack is high at edges s+ack_from .. s+ack_from+ack_len-1, s = stb rise edge.
    // dup_at > 0 re-pulses req (with different op/wdata) dup_at edges after acceptance.
    task automatic run_txn(input logic [1:0] t_op, input logic [7:0] t_wd, input logic [7:0] t_pin,
                           input int ack_from, input int ack_len, input int dup_at);
        int a, s, d, fall, first, ack_end;
        bit e, rd_ok;
        a = edge_n + 1;
        if (t_op == 2'b11) begin
            s = -1000; fall = -1000; d = a; e = 1'b1; rd_ok = 1'b0;
        end else begin
            s = a + SETUP_CYC;
            first = (ack_from > 1) ? ack_from : 1;
            if (ack_len > 0 && first < ack_from + ack_len && first <= TO_CYC) begin
                fall = s + first;
                ack_end = s + ack_from + ack_len;
                rd_ok = (t_op == 2'b10);
                if (ack_end - fall <= TO_CYC) begin
                    d = ack_end; e = 1'b0;
                end else begin
                    d = fall + TO_CYC; e = 1'b1;
                end
            end else begin
                fall = s + TO_CYC; d = fall; e = 1'b1; rd_ok = 1'b0;
            end
        end
        done_seen = 0; stb_seen = 0; busy_seen = 0;
        for (int n = a; n <= d + 2; n++) begin
            req      = (n == a) || (dup_at > 0 && n == a + dup_at);
            op       = (n == a) ? t_op : 2'b11;
            wdata    = (n == a) ? t_wd : ~t_wd;
            pdata_in = (n == fall) ? t_pin : ~t_pin;
            ack      = (n >= s + ack_from) && (n < s + ack_from + ack_len);
            tick();
            m_busy = (n >= a) && (n <= d);
            m_done = (n == d);
            m_stb  = (n >= s) && (n < fall);
            m_wr   = !((t_op[1] == 1'b0) && (n >= a) && (n <= d));
            if (n == a) begin
                m_sel = t_op; m_pout = t_wd; m_err = 1'b0;
            end
            if (n == d) m_err = e;
            if (rd_ok && n == fall) m_rdata = t_pin;
        end
        req = 1'b0;
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; op = 2'b00; wdata = 8'h00; pdata_in = 8'h00; ack = 1'b0;
        model_reset();
        #2 chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();

        // 1: write DOUT, ack rises 2 cycles after stb, falls one cycle later
        run_txn(2'b01, 8'hA5, 8'h00, 2, 1, 0);
        chk("t1_stb_cycles", stb_seen, 2);
        chk("t1_busy_cycles", busy_seen, 6);
        chk("t1_done_count", done_seen, 1);

        // 2: read DIN
        run_txn(2'b10, 8'h00, 8'h3C, 1, 1, 0);
        chk("t2_rdata", int'(rdata_o), 32'h3C);
        chk("t2_err", int'(err_o), 0);

        // 3: write DIR with no ack -> timeout
        run_txn(2'b00, 8'h11, 8'h00, 0, 0, 0);
        chk("t3_stb_cycles", stb_seen, 16);
        chk("t3_err", int'(err_o), 1);
        chk("t3_rdata_kept", int'(rdata_o), 32'h3C);

        // 4: invalid op
        run_txn(2'b11, 8'h77, 8'h00, 0, 0, 0);
        chk("t4_stb_cycles", stb_seen, 0);
        chk("t4_busy_cycles", busy_seen, 1);
        chk("t4_err", int'(err_o), 1);

        // 5: duplicate req during a read is ignored; err from t4 clears
        run_txn(2'b10, 8'h00, 8'h5A, 3, 2, 2);
        chk("t5_done_count", done_seen, 1);
        chk("t5_rdata", int'(rdata_o), 32'h5A);
        chk("t5_err_cleared", int'(err_o), 0);
        run_txn(2'b01, 8'hC3, 8'h00, 1, 1, 0);

        // ack already high when stb rises
        run_txn(2'b01, 8'h0F, 8'h00, -1, 3, 0);
        chk("pre_ack_stb_cycles", stb_seen, 1);

        // 6b: ack stuck high after rising -> release timeout
        run_txn(2'b00, 8'hF0, 8'h00, 1, 40, 0);
        chk("stuck_err", int'(err_o), 1);
        chk("stuck_busy_cycles", busy_seen, 20);
        chk("stuck_rdata_kept", int'(rdata_o), 32'h5A);

        // 6: reset during WAIT_ACK
        chk_en = 1'b0;
        req = 1'b1; op = 2'b01; wdata = 8'h99;
        tick();
        req = 1'b0;
        for (int i = 0; i < SETUP_CYC + 1; i++) tick();
        chk("rst_pre_stb", int'(stb_o), 1);
        chk("rst_pre_w_r", int'(w_r_o), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_stb", int'(stb_o), 0);
        chk("rst_async_w_r", int'(w_r_o), 1);
        chk("rst_async_busy", int'(busy_o), 0);
        chk("rst_async_rdata", int'(rdata_o), 0);
        model_reset();
        chk_en = 1'b1;
        done_seen = 0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_no_done", done_seen, 0);

        // after reset a fresh request is served
        run_txn(2'b10, 8'h00, 8'hE7, 2, 2, 0);
        chk("post_rst_rdata", int'(rdata_o), 32'hE7);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
